// File: rtl/dvi_tx_scheduler.sv
// DVI transmit scheduler: steers upstream pixels or black fill to the three
// TMDS encoders, passes sync control codes in blanking, and flags underruns
// and too-short blanking periods.
// Optional feature macro: DVI_UNDERRUN_CNT_EN adds the underrun_cnt output.
//
// Handshake: pix_valid/pix_ready. A pixel is consumed on a cycle where both
// are 1. pix_ready is combinational and only rises in RUN during active
// video; the upstream source must not wait on pix_ready before raising
// pix_valid, and a missing pixel during active video is an underrun.
module dvi_tx_scheduler #(
    parameter int CTRL_MIN = 12,
    parameter int CNT_W    = 16
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             de_in,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             pix_valid,
    input  logic [23:0]      pix_data,
    output logic             pix_ready,
    output logic             enc_de,
    output logic [7:0]       enc_data_r,
    output logic [7:0]       enc_data_g,
    output logic [7:0]       enc_data_b,
    output logic [1:0]       enc_ctrl_r,
    output logic [1:0]       enc_ctrl_g,
    output logic [1:0]       enc_ctrl_b,
    output logic             locked,
    output logic             underrun,
`ifdef DVI_UNDERRUN_CNT_EN
    output logic [CNT_W-1:0] underrun_cnt,
`endif
    output logic             ctrl_short
);

    typedef enum logic [1:0] {UNLOCKED = 2'd0, RUN = 2'd1, RECOVER = 2'd2} state_t;

    localparam int BW = $clog2(CTRL_MIN + 1);
    localparam logic [BW-1:0] CTRL_MIN_V = BW'(CTRL_MIN);

    state_t        state, state_nxt;
    logic          ur_evt;
    logic          de_prev;
    logic [BW-1:0] blank_cnt;
    logic          short_evt;

    logic          de_d;
    logic [23:0]   data_d;
    logic [1:0]    ctrl_b_d;

    // Pixel is taken only while locked and inside active video.
    assign pix_ready = (state == RUN) && de_in && pix_valid;
    assign locked    = (state == RUN);

    // Next state; frame_start wins over an underrun on the same cycle.
    always_comb begin
        state_nxt = state;
        ur_evt    = 1'b0;
        case (state)
            UNLOCKED: if (frame_start) state_nxt = RUN;
            RUN: begin
                if (de_in && !pix_valid) begin
                    ur_evt    = 1'b1;
                    state_nxt = frame_start ? RUN : RECOVER;
                end
            end
            RECOVER:  if (frame_start) state_nxt = RUN;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    // Encoder values for the next cycle: pixels, black fill or sync codes.
    always_comb begin
        de_d     = 1'b0;
        data_d   = 24'h000000;
        ctrl_b_d = 2'b00;
        if (state != UNLOCKED) begin
            if (de_in) begin
                de_d = 1'b1;
                if (state == RUN && pix_valid) data_d = pix_data;
            end else begin
                ctrl_b_d = {vsync, hsync};
            end
        end
    end

    // Blanking that starts before the first frame_start is not judged.
    assign short_evt = de_in && !de_prev && (state != UNLOCKED) && (blank_cnt < CTRL_MIN_V);

    // State register.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) state <= UNLOCKED;
        else     state <= state_nxt;
    end

    // Registered encoder outputs, one cycle behind the timing inputs.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            enc_de     <= 1'b0;
            enc_data_r <= 8'h00;
            enc_data_g <= 8'h00;
            enc_data_b <= 8'h00;
            enc_ctrl_r <= 2'b00;
            enc_ctrl_g <= 2'b00;
            enc_ctrl_b <= 2'b00;
        end else begin
            enc_de     <= de_d;
            enc_data_r <= data_d[23:16];
            enc_data_g <= data_d[15:8];
            enc_data_b <= data_d[7:0];
            enc_ctrl_r <= 2'b00;
            enc_ctrl_g <= 2'b00;
            enc_ctrl_b <= ctrl_b_d;
        end
    end

    // Saturating blanking length counter and de edge history.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            blank_cnt <= '0;
            de_prev   <= 1'b0;
        end else begin
            de_prev <= de_in;
            if (de_in)                        blank_cnt <= '0;
            else if (blank_cnt != CTRL_MIN_V) blank_cnt <= blank_cnt + 1'b1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            underrun   <= 1'b0;
            ctrl_short <= 1'b0;
        end else begin
            if (ur_evt)    underrun   <= 1'b1;
            if (short_evt) ctrl_short <= 1'b1;
        end
    end

`ifdef DVI_UNDERRUN_CNT_EN
    // Counts real entries into RECOVER, saturating at all-ones.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) underrun_cnt <= '0;
        else if (state != RECOVER && state_nxt == RECOVER && underrun_cnt != '1)
            underrun_cnt <= underrun_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_dvi_tx_scheduler.sv
// Bench for dvi_tx_scheduler: directed scenarios followed by random frames,
// every cycle compared against a behavioural model of the scheduler rules.
module tb_dvi_tx_scheduler;

    localparam int CTRL_MIN = 12;

    logic        clk_pix = 1'b0;
    logic        rst;
    logic        frame_start, de_in, hsync, vsync, pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready, enc_de, locked, underrun, ctrl_short;
    logic [7:0]  enc_data_r, enc_data_g, enc_data_b;
    logic [1:0]  enc_ctrl_r, enc_ctrl_g, enc_ctrl_b;
`ifdef DVI_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: frame seen since reset, pixel stream healthy, blanking run length.
    bit m_seen, m_ok, m_prev, m_ur, m_short;
    int m_low;
    int m_cnt;

    dvi_tx_scheduler #(.CTRL_MIN(CTRL_MIN), .CNT_W(16)) dut (
        .clk_pix(clk_pix), .rst(rst), .frame_start(frame_start), .de_in(de_in),
        .hsync(hsync), .vsync(vsync), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .enc_de(enc_de),
        .enc_data_r(enc_data_r), .enc_data_g(enc_data_g), .enc_data_b(enc_data_b),
        .enc_ctrl_r(enc_ctrl_r), .enc_ctrl_g(enc_ctrl_g), .enc_ctrl_b(enc_ctrl_b),
        .locked(locked), .underrun(underrun),
`ifdef DVI_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .ctrl_short(ctrl_short)
    );

    // Clock
    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_ok = 0; m_prev = 0; m_ur = 0; m_short = 0; m_low = 0; m_cnt = 0;
    endtask

    // One clock cycle: drive at the negedge, check pix_ready before the
    // posedge and the registered outputs just after it.
    task automatic step(input bit fs, input bit de, input bit hs, input bit vs,
                        input bit pv, input logic [23:0] d);
        logic        e_de;
        logic [23:0] e_data;
        logic [1:0]  e_ctrl_b;
        frame_start = fs; de_in = de; hsync = hs; vsync = vs; pix_valid = pv; pix_data = d;
        #1;
        chk("pix_ready", {31'd0, pix_ready}, {31'd0, m_seen && m_ok && de && pv});

        e_de = 0; e_data = 24'h0; e_ctrl_b = 2'b00;
        if (m_seen) begin
            if (de) begin
                e_de = 1;
                if (m_ok && pv) e_data = d;
            end else begin
                e_ctrl_b = {vs, hs};
            end
        end
        if (de && !m_prev && m_seen && m_low < CTRL_MIN) m_short = 1;
        m_low  = de ? 0 : m_low + 1;
        m_prev = de;
        if (m_seen && m_ok && de && !pv) begin
            m_ur = 1;
            if (!fs) begin
                m_ok = 0;
                if (m_cnt < 16'hFFFF) m_cnt++;
            end
        end
        if (fs) begin m_seen = 1; m_ok = 1; end

        @(posedge clk_pix);
        #1;
        chk("enc_de",     {31'd0, enc_de}, {31'd0, e_de});
        chk("enc_data",   {8'd0, enc_data_r, enc_data_g, enc_data_b}, {8'd0, e_data});
        chk("enc_ctrl",   {26'd0, enc_ctrl_r, enc_ctrl_g, enc_ctrl_b}, {28'd0, e_ctrl_b});
        chk("locked",     {31'd0, locked}, {31'd0, m_seen && m_ok});
        chk("underrun",   {31'd0, underrun}, {31'd0, m_ur});
        chk("ctrl_short", {31'd0, ctrl_short}, {31'd0, m_short});
`ifdef DVI_UNDERRUN_CNT_EN
        chk("underrun_cnt", {16'd0, underrun_cnt}, m_cnt);
`endif
        @(negedge clk_pix);
    endtask

    task automatic blank(input int n, input bit hs, input bit vs);
        for (int i = 0; i < n; i++) step(0, 0, hs, vs, 1, 24'h0);
    endtask

    task automatic active(input int n, input logic [23:0] d);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1, d);
    endtask

    // Random frame: frame_start in blanking, then lines of random length,
    // optionally with rare pixel drops.
    task automatic rand_frame(input int lines, input bit drops);
        step(1, 0, 0, 1, 1, 24'h0);
        for (int l = 0; l < lines; l++) begin
            int nb = $urandom_range(3, 16);
            int na = $urandom_range(4, 10);
            for (int i = 0; i < nb; i++)
                step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
            for (int i = 0; i < na; i++)
                step(0, 1, 0, 0, drops ? ($urandom_range(0, 29) != 0) : 1'b1, 24'($urandom));
        end
    endtask

    initial begin
        rst = 1; frame_start = 0; de_in = 0; hsync = 0; vsync = 0; pix_valid = 0; pix_data = 24'h0;
        model_reset();
        #1;
        chk("rst_enc_de", {31'd0, enc_de}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_flags",  {30'd0, underrun, ctrl_short}, 32'd0);
        chk("rst_outs",   {enc_data_r, enc_data_g, enc_data_b, enc_ctrl_r, enc_ctrl_g}, 32'd0);
        repeat (3) @(negedge clk_pix);
        rst = 0;

        // Unlocked blanking, then lock and 4 pixels of 112233.
        blank(14, 1, 0);
        step(1, 0, 0, 0, 1, 24'h0);
        active(4, 24'h112233);
        // Blanking with vsync=1 hsync=0, 12 cycles: legal.
        blank(12, 0, 1);
        active(6, 24'hA5C3E7);
        // 5-cycle blanking: too short.
        blank(5, 1, 0);
        active(6, 24'h0F1E2D);

        // Underrun mid-line, black to end of frame, next frame_start recovers.
        blank(12, 1, 0);
        active(3, 24'h445566);
        step(0, 1, 0, 0, 0, 24'h778899);
        active(3, 24'h445566);
        blank(12, 1, 1);
        active(4, 24'h123456);
        step(1, 0, 0, 1, 1, 24'h0);
        blank(12, 0, 0);
        active(4, 24'hFEDCBA);

        // frame_start together with a missing pixel.
        step(1, 1, 0, 0, 0, 24'h999999);
        active(4, 24'h0A0B0C);

        // Random frames, clean and with drops.
        for (int f = 0; f < 6; f++) rand_frame($urandom_range(2, 5), f[0]);

        // Asynchronous reset mid-line.
        step(1, 0, 0, 0, 1, 24'h0);
        blank(12, 0, 0);
        active(3, 24'h3C3C3C);
        rst = 1;
        #1;
        chk("async_rst_enc_de", {31'd0, enc_de}, 32'd0);
        model_reset();
        @(negedge clk_pix);
        rst = 0;
        // Active video before frame_start stays dark.
        active(5, 24'h5A5A5A);
        blank(13, 1, 1);
        step(1, 0, 0, 0, 1, 24'h0);
        active(4, 24'h6B6B6B);
        rand_frame(3, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dvi_tx_scheduler.md
DVI_TX_SCHEDULER -- requirements
Module: dvi_tx_scheduler

Interface
REQ-001 SHALL have parameter CTRL_MIN, default 12, giving the minimum legal blanking (control period) length in clk_pix cycles.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the underrun counter.
REQ-003 SHALL have port clk_pix, input, 1 bit: pixel clock; the block uses this single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port frame_start, input, 1 bit: one-cycle pulse marking the first cycle of a frame.
REQ-006 SHALL have port de_in, input, 1 bit: display-timing data enable.
REQ-007 SHALL have ports hsync and vsync, input, 1 bit each: timing syncs.
REQ-008 SHALL have port pix_valid, input, 1 bit: upstream pixel available.
REQ-009 SHALL have port pix_data, input, 24 bits: {red, green, blue}, 8 bits each.
REQ-010 SHALL have port pix_ready, output, 1 bit: pixel consumed this cycle.
REQ-011 SHALL have port enc_de, output, 1 bit: data enable to all three encoders.
REQ-012 SHALL have ports enc_data_r, enc_data_g and enc_data_b, output, 8 bits each: encoder colour data.
REQ-013 SHALL have ports enc_ctrl_r, enc_ctrl_g and enc_ctrl_b, output, 2 bits each: encoder control data.
REQ-014 SHALL have port locked, output, 1 bit: the state machine is in RUN.
REQ-015 SHALL have ports underrun and ctrl_short, output, 1 bit each: sticky error flags.

Function
REQ-016 SHALL implement states UNLOCKED, RUN and RECOVER.
REQ-017 UNLOCKED SHALL go to RUN on frame_start=1; RUN SHALL go to RECOVER on de_in=1 with pix_valid=0; RECOVER SHALL go to RUN on frame_start=1.
REQ-018 All outputs except pix_ready SHALL be registered, with exactly 1 cycle of latency from de_in, hsync, vsync and pix_data.
REQ-019 pix_ready SHALL be combinational and equal (state==RUN) && de_in && pix_valid; it SHALL be 0 in UNLOCKED and RECOVER.
REQ-020 In RUN with de_in=1 and pix_valid=1, the next cycle SHALL show enc_de=1 and enc_data_r/g/b equal to pix_data[23:16]/[15:8]/[7:0].
REQ-021 On the underrun cycle (RUN, de_in=1, pix_valid=0), and in RECOVER whenever de_in=1, the block SHALL output enc_de=1 with all data 8'h00 (black).
REQ-022 With de_in=0, the block SHALL output enc_de=0, enc_ctrl_b={vsync,hsync}, and enc_ctrl_g=enc_ctrl_r=2'b00.
REQ-023 In UNLOCKED, the block SHALL output enc_de=0 and all ctrl outputs 2'b00, regardless of de_in.
REQ-024 The block SHALL keep a saturating blank counter: it clears on de_in=1 and increments on de_in=0, saturating at CTRL_MIN.
REQ-025 ctrl_short SHALL set when de_in rises while the blank counter is below CTRL_MIN; blanking before the first frame_start after reset SHALL NOT be checked.
REQ-026 underrun SHALL set on any transition to RECOVER.
REQ-027 underrun and ctrl_short SHALL clear only on reset.
REQ-028 frame_start coincident with an underrun condition SHALL take priority: the next state is RUN, but that cycle's data is still black and underrun still sets.
REQ-029 frame_start while already in RUN SHALL keep the state in RUN and have no other effect.

Reset
REQ-030 While rst=1, asynchronously, the block SHALL force state=UNLOCKED, enc_de=0, all enc_data=0, all enc_ctrl=2'b00, locked=0, underrun=0, ctrl_short=0, blank counter=0, and underrun count=0.
REQ-031 Reset asserted mid-line SHALL drop enc_de immediately, and the block SHALL resume only after the next frame_start.

Configuration
REQ-032 With DVI_UNDERRUN_CNT_EN defined, the block SHALL add output underrun_cnt[CNT_W-1:0], which increments once per entry into RECOVER and saturates at all-ones.
REQ-033 Without DVI_UNDERRUN_CNT_EN, the port and counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-034 Reset, then frame_start, then 4 cycles with de_in=1 and pix_valid=1 carrying 24'h112233 -> 1 cycle later enc_de=1, r=8'h11, g=8'h22, b=8'h33; locked=1; pix_ready=1 on each of those cycles.
REQ-035 RUN with de_in=0, vsync=1, hsync=0 -> enc_ctrl_b=2'b10, enc_ctrl_g=2'b00, enc_ctrl_r=2'b00, enc_de=0.
REQ-036 RUN with pix_valid dropped for 1 cycle mid-line -> black data from that cycle to end of frame; underrun=1; pix_ready=0; locked=0; next frame_start restores RUN; with macro defined, underrun_cnt=1.
REQ-037 Blanking of 5 cycles between lines (CTRL_MIN=12) -> ctrl_short=1; blanking of 12 cycles -> ctrl_short remains 0.
REQ-038 rst pulsed while enc_de=1 -> enc_de=0 immediately without waiting for a clock edge; de_in=1 before frame_start -> enc_de stays 0 and pix_ready stays 0.
REQ-039 frame_start on the same cycle as a missing pixel -> state RUN next cycle; underrun=1; data 8'h00 that cycle.
